// File: rtl/aggregator_seq.sv
// aggregator_seq: sequential fuzzy rule aggregator, one rule per cycle through a shared multiply / exact divide-by-100 unit.
// Optional macro AGG_SEQ_SAT_FLAG_EN adds o_sat_flags reporting which of the two sums was clamped.
module aggregator_seq #(
  parameter int W_WIDTH = 16,
  parameter int G_MAX   = 100
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_reg_mode,
  input  logic [9*W_WIDTH-1:0] i_w_bus,
  input  logic [71:0]          i_g_bus,
  output logic                 o_busy,
  output logic                 o_out_valid,
  output logic [W_WIDTH-1:0]   o_s_w,
  output logic [W_WIDTH-1:0]   o_s_wg
`ifdef AGG_SEQ_SAT_FLAG_EN
  ,
  output logic [1:0]           o_sat_flags
`endif
);

  localparam int ACC_W  = W_WIDTH + 4;
  localparam int PROD_W = W_WIDTH + 8;
  localparam logic [W_WIDTH-1:0] S_MAX   = {1'b0, {(W_WIDTH-1){1'b1}}};
  localparam logic [ACC_W-1:0]   ACC_MAX = {4'b0000, S_MAX};
  localparam logic [7:0]         G_CEIL  = 8'(G_MAX);
  localparam logic [PROD_W-1:0]  DIVISOR = PROD_W'(100);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [9*W_WIDTH-1:0] r_w_sh;
  logic [71:0]          r_g_sh;
  logic                 r_mode;
  logic [3:0]           r_idx;
  logic [ACC_W-1:0]     r_acc_w;
  logic [ACC_W-1:0]     r_acc_wg;
  logic                 r_busy;
  logic                 r_out_valid;
  logic [W_WIDTH-1:0]   r_s_w;
  logic [W_WIDTH-1:0]   r_s_wg;

  logic                 w_load;
  logic                 w_step;
  logic                 w_done;
  logic                 w_last;
  logic [3:0]           w_rule;
  logic [W_WIDTH-1:0]   w_wt;
  logic [7:0]           w_g_raw;
  logic [7:0]           w_g_sat;
  logic [PROD_W-1:0]    w_prod;
  logic [W_WIDTH-1:0]   w_quot;
  logic                 w_clamp_w;
  logic                 w_clamp_wg;

  // Cross mode visits only the rules 01,10,11,12,21 (flat indices 1,3,4,5,7).
  function automatic logic [3:0] rule_sel(input logic mode, input logic [3:0] idx);
    logic [3:0] sel;
    if (mode) begin
      sel = idx;
    end else begin
      case (idx)
        4'd0:    sel = 4'd1;
        4'd1:    sel = 4'd3;
        4'd2:    sel = 4'd4;
        4'd3:    sel = 4'd5;
        4'd4:    sel = 4'd7;
        default: sel = 4'd4;
      endcase
    end
    return sel;
  endfunction

  assign w_last     = r_mode ? (r_idx == 4'd8) : (r_idx == 4'd4);
  assign w_rule     = rule_sel(r_mode, r_idx);
  assign w_wt       = r_w_sh[int'(w_rule)*W_WIDTH +: W_WIDTH];
  assign w_g_raw    = r_g_sh[int'(w_rule)*8 +: 8];
  assign w_g_sat    = (w_g_raw > G_CEIL) ? G_CEIL : w_g_raw;
  assign w_prod     = PROD_W'(w_wt) * PROD_W'(w_g_sat);
  assign w_quot     = W_WIDTH'(w_prod / DIVISOR);
  assign w_clamp_w  = (r_acc_w > ACC_MAX);
  assign w_clamp_wg = (r_acc_wg > ACC_MAX);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control decode per state
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: w_load = i_start;
      ST_RUN:  w_step = 1'b1;
      ST_DONE: w_done = 1'b1;
      default: w_load = 1'b0;
    endcase
  end

`ifdef AGG_SEQ_SAT_FLAG_EN
  logic [1:0] r_sat;
`endif

  // Capture, accumulation and registered result outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_w_sh      <= '0;
      r_g_sh      <= 72'd0;
      r_mode      <= 1'b0;
      r_idx       <= 4'd0;
      r_acc_w     <= '0;
      r_acc_wg    <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_s_w       <= '0;
      r_s_wg      <= '0;
`ifdef AGG_SEQ_SAT_FLAG_EN
      r_sat       <= 2'b00;
`endif
    end else begin
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_out_valid <= 1'b0;
      if (w_load) begin
        r_w_sh   <= i_w_bus;
        r_g_sh   <= i_g_bus;
        r_mode   <= i_reg_mode;
        r_idx    <= 4'd0;
        r_acc_w  <= '0;
        r_acc_wg <= '0;
      end else if (w_step) begin
        r_acc_w  <= r_acc_w + ACC_W'(w_wt);
        r_acc_wg <= r_acc_wg + ACC_W'(w_quot);
        r_idx    <= r_idx + 4'd1;
      end else if (w_done) begin
        r_s_w       <= w_clamp_w  ? S_MAX : r_acc_w[W_WIDTH-1:0];
        r_s_wg      <= w_clamp_wg ? S_MAX : r_acc_wg[W_WIDTH-1:0];
        r_out_valid <= 1'b1;
`ifdef AGG_SEQ_SAT_FLAG_EN
        r_sat       <= {w_clamp_wg, w_clamp_w};
`endif
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_out_valid = r_out_valid;
  assign o_s_w       = r_s_w;
  assign o_s_wg      = r_s_wg;
`ifdef AGG_SEQ_SAT_FLAG_EN
  assign o_sat_flags = r_sat;
`endif

endmodule

// File: tb/tb_aggregator_seq.sv
// Self-checking bench for aggregator_seq: table of vectors, scoreboard queue popped on out_valid, plus control corner sequences.
module tb_aggregator_seq;

  typedef struct {
    logic         mode;
    logic [143:0] w;
    logic [71:0]  g;
    logic [15:0]  sw;
    logic [15:0]  swg;
    logic [1:0]   sat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         reg_mode;
  logic [143:0] w_bus;
  logic [71:0]  g_bus;
  logic         busy;
  logic         out_valid;
  logic [15:0]  s_w;
  logic [15:0]  s_wg;
`ifdef AGG_SEQ_SAT_FLAG_EN
  logic [1:0]   sat_flags;
`endif

  int   total = 0;
  int   bad   = 0;
  vec_t exp_q[$];
  vec_t tbl[$];
  vec_t mon_e;

  aggregator_seq dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_reg_mode  (reg_mode),
    .i_w_bus     (w_bus),
    .i_g_bus     (g_bus),
    .o_busy      (busy),
    .o_out_valid (out_valid),
    .o_s_w       (s_w),
    .o_s_wg      (s_wg)
`ifdef AGG_SEQ_SAT_FLAG_EN
    ,
    .o_sat_flags (sat_flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic mode, input logic [143:0] w, input logic [71:0] g,
                               input logic [15:0] sw, input logic [15:0] swg, input logic [1:0] sat);
    vec_t v;
    v.mode = mode; v.w = w; v.g = g; v.sw = sw; v.swg = swg; v.sat = sat;
    return v;
  endfunction

  // Reference: plain integer sums over the active rule set, then clamp.
  function automatic vec_t model_vec(input logic mode, input logic [143:0] w, input logic [71:0] g);
    int aw = 0;
    int awg = 0;
    int wv, gv;
    bit act;
    vec_t v;
    for (int k = 0; k < 9; k++) begin
      act = mode || (k == 1) || (k == 3) || (k == 4) || (k == 5) || (k == 7);
      if (act) begin
        wv = int'(w[16*k +: 16]);
        gv = int'(g[8*k +: 8]);
        if (gv > 100) gv = 100;
        aw  += wv;
        awg += (wv * gv) / 100;
      end
    end
    v = mkv(mode, w, g, (aw > 32767) ? 16'h7FFF : 16'(aw), (awg > 32767) ? 16'h7FFF : 16'(awg),
            {(awg > 32767) ? 1'b1 : 1'b0, (aw > 32767) ? 1'b1 : 1'b0});
    return v;
  endfunction

  // Scoreboard monitor: every out_valid must match the oldest pending expectation.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("S_w", 32'(s_w), 32'(mon_e.sw));
        chk("S_wg", 32'(s_wg), 32'(mon_e.swg));
`ifdef AGG_SEQ_SAT_FLAG_EN
        chk("sat_flags", 32'(sat_flags), 32'(mon_e.sat));
`endif
      end
    end
  end

  // One aggregation: optional extra start at edge N+extra, reset at edge N+rst_at, input perturbation after capture.
  task automatic apply(input vec_t v, input int extra_at, input int rst_at, input bit perturb);
    int k;
    int n_valid;
    int lat;
    k = v.mode ? 9 : 5;
    n_valid = 0;
    lat = 0;
    @(negedge clk);
    reg_mode = v.mode;
    w_bus = v.w;
    g_bus = v.g;
    start = 1'b1;
    if (rst_at == 0) exp_q.push_back(v);
    @(posedge clk);
    for (int c = 1; c <= k + 3; c++) begin
      @(negedge clk);
      start = (c == extra_at);
      rst = (c == rst_at);
      if (perturb) begin
        w_bus = ~w_bus;
        g_bus = ~g_bus;
        reg_mode = ~v.mode;
      end
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        n_valid++;
        lat = c;
      end
      if (rst_at == 0 && c == 1) chk("busy_run", 32'(busy), 32'd1);
      if (rst_at == 0 && c == k) chk("busy_done", 32'(busy), 32'd1);
      if (rst_at == 0 && c == k + 1) chk("busy_idle", 32'(busy), 32'd0);
      if (rst_at != 0 && c == rst_at) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_S_w", 32'(s_w), 32'd0);
        chk("rst_S_wg", 32'(s_wg), 32'd0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    if (rst_at != 0) begin
      chk("rst_no_valid", 32'(n_valid), 32'd0);
    end else begin
      chk("valid_count", 32'(n_valid), 32'd1);
      chk("latency", 32'(lat), 32'(k + 1));
      chk("hold_S_w", 32'(s_w), 32'(v.sw));
      chk("hold_S_wg", 32'(s_wg), 32'(v.swg));
    end
  endtask

  logic [143:0] w;
  logic [71:0]  g;
  logic [15:0]  wv;
  logic [7:0]   gv;

  initial begin
    rst = 1'b1; start = 1'b0; reg_mode = 1'b0; w_bus = 144'd0; g_bus = 72'd0;

    // Vector table (expected values derived by hand)
    wv = 16'h1000; gv = 8'd50; w = {9{wv}}; g = {9{gv}};
    tbl.push_back(mkv(1'b1, w, g, 16'h7FFF, 16'h4800, 2'b01));
    wv = 16'h7FFF; gv = 8'd100; w = {9{wv}}; g = {9{gv}};
    w[16*4 +: 16] = 16'h4000; g[8*4 +: 8] = 8'd100;
    w[16*1 +: 16] = 16'h0800; g[8*1 +: 8] = 8'd0;
    w[16*3 +: 16] = 16'h0800; g[8*3 +: 8] = 8'd0;
    w[16*5 +: 16] = 16'h0800; g[8*5 +: 8] = 8'd0;
    w[16*7 +: 16] = 16'h0800; g[8*7 +: 8] = 8'd0;
    tbl.push_back(mkv(1'b0, w, g, 16'h6000, 16'h4000, 2'b00));
    w = 144'd0; g = 72'd0; w[15:0] = 16'h0003; g[7:0] = 8'd33;
    tbl.push_back(mkv(1'b1, w, g, 16'h0003, 16'h0000, 2'b00));
    g[7:0] = 8'd34;
    tbl.push_back(mkv(1'b1, w, g, 16'h0003, 16'h0001, 2'b00));
    w = 144'd0; g = 72'd0; w[143:128] = 16'h2000; g[71:64] = 8'd200;
    tbl.push_back(mkv(1'b1, w, g, 16'h2000, 16'h2000, 2'b00));
    wv = 16'h7FFF; gv = 8'd100; w = {9{wv}}; g = {9{gv}};
    tbl.push_back(mkv(1'b1, w, g, 16'h7FFF, 16'h7FFF, 2'b11));
    wv = 16'hFFFF; w = {9{wv}};
    tbl.push_back(mkv(1'b0, w, g, 16'h7FFF, 16'h7FFF, 2'b11));
    w = 144'd0; g = 72'd0; w[31:16] = 16'h7FFF; g[15:8] = 8'd99;
    tbl.push_back(mkv(1'b0, w, g, 16'h7FFF, 16'h7EB7, 2'b00));
    w = 144'd0; g = 72'd0; w[15:0] = 16'h7FFF; w[31:16] = 16'h0001;
    tbl.push_back(mkv(1'b1, w, g, 16'h7FFF, 16'h0000, 2'b01));
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 9; k++) begin
        w[16*k +: 16] = 16'($urandom_range(0, 32767));
        g[8*k +: 8]   = 8'($urandom_range(0, 255));
      end
      tbl.push_back(model_vec((i % 2) == 0, w, g));
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_S_w", 32'(s_w), 32'd0);
    chk("reset_S_wg", 32'(s_wg), 32'd0);
`ifdef AGG_SEQ_SAT_FLAG_EN
    chk("reset_sat", 32'(sat_flags), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], 0, 0, 1'b0);
    end

    // Control corner sequences
    apply(tbl[0], 3, 0, 1'b0);
    apply(tbl[1], 0, 0, 1'b1);
    apply(tbl[5], 0, 4, 1'b0);
    apply(tbl[3], 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
